// File: rtl/inport_ctrl_pkg.sv
// Shared constants for the router input-port controller: flit layout,
// flit type codes, crossbar port codes, FSM states and the XY route function.
package inport_ctrl_pkg;

  // Flit MSB index, VC MSB index, port-code MSB index, grant-vector MSB index.
  localparam int DATAW = 15;
  localparam int VCHW  = 1;
  localparam int PORTW = 2;
  localparam int PORT  = 4;
  localparam int NPORT = PORT + 1;

  // Position of the two-bit flit type field inside a flit.
  localparam int FT_HI = DATAW;
  localparam int FT_LO = DATAW - 1;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_t;

  localparam logic [PORTW:0] P_LOCAL = 3'd0;
  localparam logic [PORTW:0] P_NORTH = 3'd1;
  localparam logic [PORTW:0] P_EAST  = 3'd2;
  localparam logic [PORTW:0] P_SOUTH = 3'd3;
  localparam logic [PORTW:0] P_WEST  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  // Dimension-ordered routing: resolve X completely before moving in Y.
  function automatic logic [PORTW:0] xy_route(input int dst_x, input int dst_y,
                                              input int router_x, input int router_y);
    if (dst_x > router_x) return P_EAST;
    if (dst_x < router_x) return P_WEST;
    if (dst_y > router_y) return P_NORTH;
    if (dst_y < router_y) return P_SOUTH;
    return P_LOCAL;
  endfunction

endpackage

// File: rtl/inport_ctrl_inbuf_fifo.sv
// Input flit buffer: circular FIFO of {vc, flit} words. The head word is
// only meaningful while empty is low (no write-to-read fall-through).
module inbuf_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_wr;
  logic          do_rd;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO still accepts a write when a read frees a slot the same cycle.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= bump(wr_ptr);
      if (do_rd) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  // Storage array write port.
  // NOTE: the array is deliberately not reset; empty gates its contents, and a reset would cost a flop-based array.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inport_ctrl.sv
// Router input-port controller: buffers incoming flits, XY-routes each head
// flit, requests the chosen crossbar output and streams the packet once
// granted, limited by per-output downstream credits.
module inport_ctrl
  import inport_ctrl_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int CRD      = 4,
  parameter int ADDRW    = 2,
  parameter int ROUTER_X = 0,
  parameter int ROUTER_Y = 0
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DATAW:0]   idata,
  input  logic             ivalid,
  input  logic [VCHW:0]    ivch,
  output logic             ocredit,
  output logic [PORTW:0]   port,
  output logic             req,
  input  logic [PORT:0]    grt,
  output logic [DATAW:0]   odata,
  output logic             ovalid,
  output logic [VCHW:0]    ovch,
  input  logic [PORT:0]    dcrd
);

  localparam int W  = VCHW + 1 + DATAW + 1;
  localparam int CW = $clog2(CRD + 1);

  state_t                     state;
  logic [W-1:0]               head;
  logic                       full;
  logic                       empty;
  flit_type_t                 head_type;
  logic                       head_is_head;
  logic                       head_is_tail;
  logic                       send;
  logic                       drop;
  logic                       rd;
  logic [PORT:0]              dec;
  logic [NPORT-1:0][CW-1:0]   crd;

  inbuf_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .wr    (ivalid),
    .wdata ({ivch, idata}),
    .rd    (rd),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign head_type    = flit_type_t'(head[FT_HI:FT_LO]);
  assign head_is_head = (head_type == FT_HEAD) || (head_type == FT_SINGLE);
  assign head_is_tail = (head_type == FT_TAIL) || (head_type == FT_SINGLE);

  // A flit leaves only in ACTIVE with data, a live grant and a downstream slot.
  assign send = (state == S_ACTIVE) && !empty && grt[port] && (crd[port] != '0);
  // A stray body/tail flit at the front while idle is discarded.
  assign drop = (state == S_IDLE) && !empty && !head_is_head;
  assign rd   = send || drop;
  assign dec  = send ? (NPORT'(1) << port) : '0;

  assign ovalid = send;
  assign odata  = send ? head[DATAW:0] : '0;
  assign ovch   = send ? head[W-1:DATAW+1] : '0;

  // Request/stream FSM with registered req, port and upstream credit pulse.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state   <= S_IDLE;
      req     <= 1'b0;
      port    <= P_LOCAL;
      ocredit <= 1'b0;
    end else begin
      ocredit <= rd;
      assert (!(ivalid && full && !rd))
        else $error("inport_ctrl: flit written into a full buffer was dropped");
      case (state)
        S_IDLE: begin
          assert (empty || head_is_head)
            else $error("inport_ctrl: non-head flit at buffer front while idle");
          if (!empty && head_is_head) begin
            port  <= xy_route(int'(head[2*ADDRW-1:ADDRW]), int'(head[ADDRW-1:0]),
                              ROUTER_X, ROUTER_Y);
            req   <= 1'b1;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (grt[port]) state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (send && head_is_tail) begin
            req   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Per-output downstream credit counters; a return and a send cancel out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPORT; i++) begin
      if (!rst_) begin
        crd[i] <= CW'(CRD);
      end else if (dcrd[i] && !dec[i]) begin
        assert (crd[i] != CW'(CRD))
          else $error("inport_ctrl: credit return on output %0d already at maximum", i);
        if (crd[i] != CW'(CRD)) crd[i] <= crd[i] + 1'b1;
      end else if (dec[i] && !dcrd[i]) begin
        crd[i] <= crd[i] - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inport_ctrl.sv
// Directed bench for inport_ctrl: reset, single-flit routing, streaming,
// credit starvation (CRD=2 instance), grant gaps, back-to-back packets and
// mid-packet reset. Expected values are hand-derived cycle by cycle.
module tb_inport_ctrl;
  import inport_ctrl_pkg::*;

  logic             clk;
  logic             rst_;
  logic             rst2;
  logic [DATAW:0]   idata;
  logic             ivalid;
  logic [VCHW:0]    ivch;
  logic [PORT:0]    grt;
  logic [PORT:0]    dcrd;

  logic             ocredit, req, ovalid;
  logic [PORTW:0]   port;
  logic [DATAW:0]   odata;
  logic [VCHW:0]    ovch;

  logic             ocredit2, req2, ovalid2;
  logic [PORTW:0]   port2;
  logic [DATAW:0]   odata2;
  logic [VCHW:0]    ovch2;

  int n_checks = 0;
  int n_fail   = 0;

  inport_ctrl #(.DEPTH(4), .CRD(4), .ADDRW(2), .ROUTER_X(1), .ROUTER_Y(1)) u_dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .ocredit(ocredit), .port(port), .req(req), .grt(grt),
    .odata(odata), .ovalid(ovalid), .ovch(ovch), .dcrd(dcrd)
  );

  // Second instance with shallow downstream credit, held in reset except during starvation steps.
  inport_ctrl #(.DEPTH(4), .CRD(2), .ADDRW(2), .ROUTER_X(1), .ROUTER_Y(1)) u_dut2 (
    .clk(clk), .rst_(rst2), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .ocredit(ocredit2), .port(port2), .req(req2), .grt(grt),
    .odata(odata2), .ovalid(ovalid2), .ovch(ovch2), .dcrd(dcrd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [DATAW:0] mk_head(input logic [1:0] t, input logic [1:0] x,
                                             input logic [1:0] y);
    return {t, 10'h000, x, y};
  endfunction

  function automatic logic [DATAW:0] mk_body(input logic [1:0] t, input logic [7:0] p);
    return {t, 6'h00, p};
  endfunction

  logic [DATAW:0] f_a;
  logic [DATAW:0] pa0, pa1, pb;
  logic [DATAW:0] pk  [4];
  logic [DATAW:0] pk2 [4];
  logic [DATAW:0] pk3 [4];

  initial begin
    // Reset held two cycles with ivalid asserted: nothing may be buffered.
    rst_ = 1'b0; rst2 = 1'b0; ivalid = 1'b1; ivch = '0; grt = '0; dcrd = '0;
    idata = mk_head(FT_SINGLE, 2'd2, 2'd1);
    cyc(); cyc(); settle();
    check("rst_req", req, 0);
    check("rst_ovalid", ovalid, 0);
    check("rst_ocredit", ocredit, 0);
    check("rst_port", port, 0);
    check("rst_odata", odata, 0);
    check("rst_empty", u_dut.empty, 1);
    for (int i = 0; i < NPORT; i++) check("rst_crd", u_dut.crd[i], 4);
    rst_ = 1'b1; ivalid = 1'b0;
    cyc();

    // Single head+tail flit to (2,1) from router (1,1): route east.
    f_a = mk_head(FT_SINGLE, 2'd2, 2'd1);
    ivch = 2'd1; ivalid = 1'b1; idata = f_a;
    cyc();
    ivalid = 1'b0; ivch = '0; settle();
    check("t2_req_pre", req, 0);
    cyc(); settle();
    check("t2_req", req, 1);
    check("t2_port", port, P_EAST);
    cyc(); settle();
    check("t2_no_grant_ovalid", ovalid, 0);
    cyc(); grt = 5'b00100; settle();
    check("t2_req_hold", req, 1);
    check("t2_grant_cycle_ovalid", ovalid, 0);
    cyc(); settle();
    check("t2_ovalid", ovalid, 1);
    check("t2_odata", odata, f_a);
    check("t2_ovch", ovch, 1);
    cyc(); settle();
    check("t2_req_drop", req, 0);
    check("t2_ovalid_after", ovalid, 0);
    check("t2_ocredit", ocredit, 1);
    check("t2_crd", u_dut.crd[2], 3);
    cyc(); grt = '0; settle();
    check("t2_ocredit_single", ocredit, 0);
    dcrd = 5'b00100; cyc(); dcrd = '0; settle();
    check("t2_crd_back", u_dut.crd[2], 4);

    // Four-flit packet to local (1,1), grant held: four consecutive flits.
    pk = '{mk_head(FT_HEAD, 2'd1, 2'd1), mk_body(FT_BODY, 8'hA1),
           mk_body(FT_BODY, 8'hA2), mk_body(FT_TAIL, 8'hA3)};
    grt = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      ivalid = 1'b1; idata = pk[i]; settle();
      check("t3_fill_ovalid", ovalid, (i == 3) ? 1 : 0);
      check("t3_fill_odata", odata, (i == 3) ? pk[0] : '0);
      cyc();
    end
    ivalid = 1'b0;
    for (int j = 1; j < 4; j++) begin
      settle();
      check("t3_ovalid", ovalid, 1);
      check("t3_odata", odata, pk[j]);
      check("t3_req", req, 1);
      cyc();
    end
    settle();
    check("t3_req_drop", req, 0);
    check("t3_ovalid_end", ovalid, 0);
    check("t3_crd0", u_dut.crd[0], 0);
    check("t3_ocredit", ocredit, 1);
    check("t3_empty", u_dut.empty, 1);
    grt = '0; dcrd = 5'b00001;
    repeat (4) cyc();
    dcrd = '0; settle();
    check("t3_crd_back", u_dut.crd[0], 4);

    // Credit starvation on the CRD=2 instance, packet to east.
    rst2 = 1'b1; cyc();
    pk2 = '{mk_head(FT_HEAD, 2'd2, 2'd1), mk_body(FT_BODY, 8'hB1),
            mk_body(FT_BODY, 8'hB2), mk_body(FT_TAIL, 8'hB3)};
    grt = 5'b00100;
    for (int i = 0; i < 4; i++) begin
      ivalid = 1'b1; idata = pk2[i]; settle();
      check("t4_fill_ovalid", ovalid2, (i == 3) ? 1 : 0);
      cyc();
    end
    ivalid = 1'b0; settle();
    check("t4_second_ovalid", ovalid2, 1);
    check("t4_second_odata", odata2, pk2[1]);
    cyc(); settle();
    check("t4_starved", ovalid2, 0);
    check("t4_starved_req", req2, 1);
    cyc(); dcrd = 5'b00100; settle();
    check("t4_starved2", ovalid2, 0);
    cyc(); dcrd = '0; settle();
    check("t4_release_ovalid", ovalid2, 1);
    check("t4_release_odata", odata2, pk2[2]);
    cyc(); settle();
    check("t4_one_only", ovalid2, 0);
    dcrd = 5'b00100; cyc(); dcrd = '0; settle();
    check("t4_tail_ovalid", ovalid2, 1);
    check("t4_tail_odata", odata2, pk2[3]);
    cyc(); settle();
    check("t4_req_drop", req2, 0);
    check("t4_crd", u_dut2.crd[2], 0);
    rst2 = 1'b0; rst_ = 1'b0; grt = '0;
    cyc();
    rst_ = 1'b1;
    cyc();

    // Grant withdrawn for three cycles mid-packet, packet to south (1,0).
    pk3 = '{mk_head(FT_HEAD, 2'd1, 2'd0), mk_body(FT_BODY, 8'hC1),
            mk_body(FT_BODY, 8'hC2), mk_body(FT_TAIL, 8'hC3)};
    grt = 5'b01000;
    for (int i = 0; i < 4; i++) begin
      ivalid = 1'b1; idata = pk3[i]; settle();
      check("t5_fill_odata", odata, (i == 3) ? pk3[0] : '0);
      cyc();
    end
    ivalid = 1'b0; settle();
    check("t5_port", port, P_SOUTH);
    check("t5_b1", odata, pk3[1]);
    cyc();
    grt = '0;
    for (int g = 0; g < 3; g++) begin
      settle();
      check("t5_gap_ovalid", ovalid, 0);
      check("t5_gap_req", req, 1);
      cyc();
    end
    grt = 5'b01000; settle();
    check("t5_resume_ovalid", ovalid, 1);
    check("t5_b2", odata, pk3[2]);
    cyc(); settle();
    check("t5_tail", odata, pk3[3]);
    cyc(); settle();
    check("t5_req_drop", req, 0);
    check("t5_empty", u_dut.empty, 1);
    check("t5_crd3", u_dut.crd[3], 0);
    grt = '0; dcrd = 5'b01000;
    repeat (4) cyc();
    dcrd = '0;

    // Back-to-back packets east then north with all grants given.
    pa0 = mk_head(FT_HEAD, 2'd3, 2'd0);
    pa1 = mk_body(FT_TAIL, 8'hD1);
    pb  = mk_head(FT_SINGLE, 2'd1, 2'd3);
    grt = 5'b11111;
    ivalid = 1'b1; idata = pa0; cyc();
    idata = pa1; cyc();
    idata = pb; cyc();
    ivalid = 1'b0; settle();
    check("t6_a0", odata, pa0);
    check("t6_port_east", port, P_EAST);
    cyc(); settle();
    check("t6_a1_ovalid", ovalid, 1);
    check("t6_a1", odata, pa1);
    cyc(); settle();
    check("t6_bubble1_req", req, 0);
    check("t6_bubble1_ovalid", ovalid, 0);
    cyc(); settle();
    check("t6_bubble2_req", req, 1);
    check("t6_port_north", port, P_NORTH);
    check("t6_bubble2_ovalid", ovalid, 0);
    cyc(); settle();
    check("t6_b_ovalid", ovalid, 1);
    check("t6_b", odata, pb);
    cyc();

    // Reset in the middle of a local packet.
    for (int i = 0; i < 4; i++) begin
      ivalid = 1'b1; idata = pk[i];
      cyc();
    end
    ivalid = 1'b0; rst_ = 1'b0; settle();
    check("t7_active_before_reset", ovalid, 1);
    cyc(); settle();
    check("t7_req", req, 0);
    check("t7_ovalid", ovalid, 0);
    check("t7_empty", u_dut.empty, 1);
    check("t7_crd0", u_dut.crd[0], 4);
    check("t7_crd2", u_dut.crd[2], 4);
    check("t7_ocredit", ocredit, 0);
    rst_ = 1'b1;
    cyc(); cyc(); settle();
    check("t7_idle_req", req, 0);
    check("t7_idle_ovalid", ovalid, 0);
    check("t7_idle_ocredit", ocredit, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
